// File: rtl/lynx_tap_loader_if.sv
// HPS ioctl download stream in, tape RAM-port writes and load status out.
interface lynx_tap_loader_if;
    logic        ioctl_download;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_data;
    logic [7:0]  ioctl_index;
    logic [15:0] tape_addr;
    logic [7:0]  tape_dout;
    logic        tape_wr;
    logic [15:0] tape_exec;
    logic        tape_complete;
    logic        tape_error;
    logic        busy;

    modport master (
        output ioctl_download, ioctl_wr, ioctl_addr, ioctl_data, ioctl_index,
        input  tape_addr, tape_dout, tape_wr, tape_exec, tape_complete, tape_error, busy
    );

    modport slave (
        input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_data, ioctl_index,
        output tape_addr, tape_dout, tape_wr, tape_exec, tape_complete, tape_error, busy
    );
endinterface

// File: rtl/lynx_tap_loader.sv
// Parses a Lynx machine-code tape image from the ioctl stream and writes its payload to RAM.
// Latency: one cycle from accepted data byte to tape_wr; tape_complete one cycle after checksum.
// Backpressure: none; a byte per clock is absorbed, out-of-order or truncated images go to ERR.
module lynx_tap_loader #(
    parameter logic [7:0]  TAP_INDEX = 8'h01,
    parameter logic [7:0]  TYPE_BYTE = 8'h4D,
    parameter logic [15:0] MAX_LEN   = 16'hC000
) (
    input  logic clock,
    input  logic reset,
    lynx_tap_loader_if.slave bus
);

    typedef enum logic [2:0] {IDLE, HDR, DATA, CSUM, DONE, ERR} state_t;

    state_t      state;
    logic [24:0] offset;
    logic [15:0] load_addr;
    logic [15:0] length;
    logic [15:0] exec_addr;
    logic [15:0] ptr;
    logic [15:0] remaining;
    logic [7:0]  sum;

    logic accept;
    logic addr_ok;

    assign accept  = bus.ioctl_download && bus.ioctl_wr && (bus.ioctl_index == TAP_INDEX);
    assign addr_ok = (bus.ioctl_addr == offset);
    assign bus.busy = (state == HDR) || (state == DATA) || (state == CSUM);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state             <= IDLE;
            offset            <= '0;
            load_addr         <= '0;
            length            <= '0;
            exec_addr         <= '0;
            ptr               <= '0;
            remaining         <= '0;
            sum               <= '0;
            bus.tape_addr     <= '0;
            bus.tape_dout     <= '0;
            bus.tape_wr       <= 1'b0;
            bus.tape_exec     <= '0;
            bus.tape_complete <= 1'b0;
            bus.tape_error    <= 1'b0;
        end else begin
            bus.tape_wr       <= 1'b0;
            bus.tape_complete <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept && bus.ioctl_addr == '0) begin
                        offset <= 25'd1;
                        sum    <= '0;
                        if (bus.ioctl_data != TYPE_BYTE) begin
                            state          <= ERR;
                            bus.tape_error <= 1'b1;
                        end else begin
                            state          <= HDR;
                            bus.tape_error <= 1'b0;
                        end
                    end
                end
                HDR: begin
                    if (accept) begin
                        offset <= offset + 25'd1;
                        if (!addr_ok) begin
                            state          <= ERR;
                            bus.tape_error <= 1'b1;
                        end else begin
                            case (offset[2:0])
                                3'd1: load_addr[7:0]  <= bus.ioctl_data;
                                3'd2: load_addr[15:8] <= bus.ioctl_data;
                                3'd3: length[7:0]     <= bus.ioctl_data;
                                3'd4: begin
                                    length[15:8] <= bus.ioctl_data;
                                    if ({bus.ioctl_data, length[7:0]} > MAX_LEN) begin
                                        state          <= ERR;
                                        bus.tape_error <= 1'b1;
                                    end
                                end
                                3'd5: exec_addr[7:0]  <= bus.ioctl_data;
                                3'd6: begin
                                    exec_addr[15:8] <= bus.ioctl_data;
                                    ptr             <= load_addr;
                                    remaining       <= length;
                                    sum             <= '0;
                                    state           <= (length == '0) ? CSUM : DATA;
                                end
                                default: begin
                                    state          <= ERR;
                                    bus.tape_error <= 1'b1;
                                end
                            endcase
                        end
                    end else if (!bus.ioctl_download) begin
                        state          <= ERR;
                        bus.tape_error <= 1'b1;
                    end
                end
                DATA: begin
                    if (accept) begin
                        offset <= offset + 25'd1;
                        if (!addr_ok) begin
                            state          <= ERR;
                            bus.tape_error <= 1'b1;
                        end else begin
                            bus.tape_addr <= ptr;
                            bus.tape_dout <= bus.ioctl_data;
                            bus.tape_wr   <= 1'b1;
                            ptr           <= ptr + 16'd1;
                            sum           <= sum + bus.ioctl_data;
                            remaining     <= remaining - 16'd1;
                            if (remaining == 16'd1)
                                state <= CSUM;
                        end
                    end else if (!bus.ioctl_download) begin
                        state          <= ERR;
                        bus.tape_error <= 1'b1;
                    end
                end
                CSUM: begin
                    if (accept) begin
                        offset <= offset + 25'd1;
                        if (addr_ok && bus.ioctl_data == sum) begin
                            state             <= DONE;
                            bus.tape_exec     <= exec_addr;
                            bus.tape_complete <= 1'b1;
                        end else begin
                            state          <= ERR;
                            bus.tape_error <= 1'b1;
                        end
                    end else if (!bus.ioctl_download) begin
                        state          <= ERR;
                        bus.tape_error <= 1'b1;
                    end
                end
                // Trailing bytes are ignored here; only the end of the download matters.
                DONE, ERR: begin
                    if (!bus.ioctl_download)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lynx_tap_loader.sv
// Directed bench for lynx_tap_loader: valid, corrupt, wrapping, truncated and reset-interrupted images.
module tb_lynx_tap_loader;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   total = 0;
    int   bad   = 0;

    lynx_tap_loader_if bus();

    lynx_tap_loader dut (.clock(clock), .reset(reset), .bus(bus.slave));

    always #5 clock = ~clock;

    logic [15:0] wa_q[$];
    logic [7:0]  wd_q[$];
    int          cmp_cnt = 0;
    int          overlap = 0;

    always @(negedge clock) begin
        if (bus.tape_wr) begin
            wa_q.push_back(bus.tape_addr);
            wd_q.push_back(bus.tape_dout);
        end
        if (bus.tape_complete) cmp_cnt++;
        if (bus.tape_wr && bus.tape_complete) overlap++;
    end

    logic [7:0] img[$];
    int wbase;
    int cbase;

    task automatic mark();
        wbase = wa_q.size();
        cbase = cmp_cnt;
    endtask

    task automatic run_image(input logic [7:0] idx, input int nsend, input int gap);
        @(negedge clock);
        bus.ioctl_download = 1'b1;
        bus.ioctl_index    = idx;
        for (int i = 0; i < nsend; i++) begin
            bus.ioctl_wr   = 1'b1;
            bus.ioctl_addr = 25'(i);
            bus.ioctl_data = img[i];
            @(negedge clock);
            bus.ioctl_wr = 1'b0;
            repeat (gap) @(negedge clock);
        end
        repeat (3) @(negedge clock);
        bus.ioctl_download = 1'b0;
        repeat (3) @(negedge clock);
    endtask

    task automatic basic_img(input logic [7:0] csum);
        img = '{8'h4D, 8'h00, 8'h80, 8'h03, 8'h00, 8'h00, 8'h80, 8'h11, 8'h22, 8'h33, csum};
    endtask

    task automatic test_reset();
        #1;
        total++; if (bus.tape_wr !== 1'b0) begin bad++; $display("FAIL reset_wr got=%b exp=0", bus.tape_wr); end
        total++; if (bus.tape_addr !== 16'h0) begin bad++; $display("FAIL reset_addr got=%h exp=0000", bus.tape_addr); end
        total++; if (bus.tape_dout !== 8'h0) begin bad++; $display("FAIL reset_dout got=%h exp=00", bus.tape_dout); end
        total++; if (bus.tape_exec !== 16'h0) begin bad++; $display("FAIL reset_exec got=%h exp=0000", bus.tape_exec); end
        total++; if ({bus.tape_complete, bus.tape_error, bus.busy} !== 3'b000) begin bad++;
            $display("FAIL reset_flags got=%b exp=000", {bus.tape_complete, bus.tape_error, bus.busy}); end
        repeat (2) @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);
    endtask

    task automatic test_basic(input int gap);
        logic [23:0] exp_w[3];
        exp_w = '{24'h8000_11, 24'h8001_22, 24'h8002_33};
        basic_img(8'h66);
        mark();
        run_image(8'h01, 11, gap);
        total++; if (wa_q.size() - wbase !== 3) begin bad++; $display("FAIL basic_wcnt got=%0d exp=3", wa_q.size() - wbase); end
        for (int i = 0; i < 3 && wbase + i < wa_q.size(); i++) begin
            total++; if ({wa_q[wbase+i], wd_q[wbase+i]} !== exp_w[i]) begin bad++;
                $display("FAIL basic_w%0d got=%h exp=%h", i, {wa_q[wbase+i], wd_q[wbase+i]}, exp_w[i]); end
        end
        total++; if (cmp_cnt - cbase !== 1) begin bad++; $display("FAIL basic_complete got=%0d exp=1", cmp_cnt - cbase); end
        total++; if (bus.tape_exec !== 16'h8000) begin bad++; $display("FAIL basic_exec got=%h exp=8000", bus.tape_exec); end
        total++; if ({bus.tape_error, bus.busy} !== 2'b00) begin bad++; $display("FAIL basic_flags got=%b exp=00", {bus.tape_error, bus.busy}); end
    endtask

    task automatic test_bad_csum();
        basic_img(8'h67);
        mark();
        run_image(8'h01, 11, 0);
        total++; if (wa_q.size() - wbase !== 3) begin bad++; $display("FAIL csum_wcnt got=%0d exp=3", wa_q.size() - wbase); end
        total++; if (cmp_cnt - cbase !== 0) begin bad++; $display("FAIL csum_complete got=%0d exp=0", cmp_cnt - cbase); end
        total++; if (bus.tape_error !== 1'b1) begin bad++; $display("FAIL csum_error got=%b exp=1", bus.tape_error); end
        total++; if (bus.tape_exec !== 16'h8000) begin bad++; $display("FAIL csum_exec got=%h exp=8000", bus.tape_exec); end
    endtask

    task automatic test_wrap();
        logic [23:0] exp_w[3];
        exp_w = '{24'hFFFE_AA, 24'hFFFF_BB, 24'h0000_CC};
        img = '{8'h4D, 8'hFE, 8'hFF, 8'h03, 8'h00, 8'h34, 8'h12, 8'hAA, 8'hBB, 8'hCC, 8'h31, 8'h55};
        mark();
        run_image(8'h01, 12, 0);
        total++; if (wa_q.size() - wbase !== 3) begin bad++; $display("FAIL wrap_wcnt got=%0d exp=3", wa_q.size() - wbase); end
        for (int i = 0; i < 3 && wbase + i < wa_q.size(); i++) begin
            total++; if ({wa_q[wbase+i], wd_q[wbase+i]} !== exp_w[i]) begin bad++;
                $display("FAIL wrap_w%0d got=%h exp=%h", i, {wa_q[wbase+i], wd_q[wbase+i]}, exp_w[i]); end
        end
        total++; if (cmp_cnt - cbase !== 1) begin bad++; $display("FAIL wrap_complete got=%0d exp=1", cmp_cnt - cbase); end
        total++; if (bus.tape_exec !== 16'h1234) begin bad++; $display("FAIL wrap_exec got=%h exp=1234", bus.tape_exec); end
        total++; if (bus.tape_error !== 1'b0) begin bad++; $display("FAIL wrap_error got=%b exp=0", bus.tape_error); end
    endtask

    task automatic test_hdr_errors();
        img = '{8'h42, 8'h00, 8'h80, 8'h03, 8'h00, 8'h00, 8'h80, 8'h11, 8'h22, 8'h33, 8'h66};
        mark();
        run_image(8'h01, 11, 0);
        total++; if (wa_q.size() - wbase !== 0) begin bad++; $display("FAIL type_wcnt got=%0d exp=0", wa_q.size() - wbase); end
        total++; if (bus.tape_error !== 1'b1) begin bad++; $display("FAIL type_error got=%b exp=1", bus.tape_error); end
        test_basic(0);
        img = '{8'h4D, 8'h00, 8'h80, 8'h01, 8'hC0, 8'h00, 8'h80, 8'h11, 8'h22, 8'h33, 8'h66};
        mark();
        run_image(8'h01, 11, 0);
        total++; if (wa_q.size() - wbase !== 0) begin bad++; $display("FAIL len_wcnt got=%0d exp=0", wa_q.size() - wbase); end
        total++; if ({bus.tape_error, bus.busy} !== 2'b10) begin bad++; $display("FAIL len_flags got=%b exp=10", {bus.tape_error, bus.busy}); end
        test_basic(0);
    endtask

    task automatic test_index_and_truncate();
        basic_img(8'h66);
        mark();
        run_image(8'h02, 11, 0);
        total++; if (wa_q.size() - wbase !== 0) begin bad++; $display("FAIL idx_wcnt got=%0d exp=0", wa_q.size() - wbase); end
        total++; if ({cmp_cnt - cbase, bus.tape_error, bus.busy} !== {32'd0, 2'b00}) begin bad++;
            $display("FAIL idx_flags got=%0d/%b%b exp=0/00", cmp_cnt - cbase, bus.tape_error, bus.busy); end
        mark();
        run_image(8'h01, 9, 0);
        total++; if (wa_q.size() - wbase !== 2) begin bad++; $display("FAIL trunc_wcnt got=%0d exp=2", wa_q.size() - wbase); end
        total++; if ({bus.tape_error, bus.busy} !== 2'b10) begin bad++; $display("FAIL trunc_flags got=%b exp=10", {bus.tape_error, bus.busy}); end
        total++; if (cmp_cnt - cbase !== 0) begin bad++; $display("FAIL trunc_complete got=%0d exp=0", cmp_cnt - cbase); end
    endtask

    task automatic test_reset_mid();
        basic_img(8'h66);
        @(negedge clock);
        bus.ioctl_download = 1'b1;
        bus.ioctl_index    = 8'h01;
        for (int i = 0; i < 9; i++) begin
            bus.ioctl_wr   = 1'b1;
            bus.ioctl_addr = 25'(i);
            bus.ioctl_data = img[i];
            if (i < 8) @(negedge clock);
        end
        @(posedge clock);
        #1;
        total++; if ({bus.tape_wr, bus.busy} !== 2'b11) begin bad++; $display("FAIL mid_active got=%b exp=11", {bus.tape_wr, bus.busy}); end
        #1 reset = 1'b0;
        #1;
        total++; if ({bus.tape_wr, bus.busy, bus.tape_error, bus.tape_complete} !== 4'b0000) begin bad++;
            $display("FAIL mid_reset_flags got=%b exp=0000", {bus.tape_wr, bus.busy, bus.tape_error, bus.tape_complete}); end
        total++; if ({bus.tape_addr, bus.tape_dout, bus.tape_exec} !== 40'h0) begin bad++;
            $display("FAIL mid_reset_bus got=%h exp=0", {bus.tape_addr, bus.tape_dout, bus.tape_exec}); end
        bus.ioctl_wr = 1'b0;
        bus.ioctl_download = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        test_basic(0);
    endtask

    initial begin
        bus.ioctl_download = 1'b0;
        bus.ioctl_wr       = 1'b0;
        bus.ioctl_addr     = '0;
        bus.ioctl_data     = '0;
        bus.ioctl_index    = '0;
        test_reset();
        test_basic(1);
        test_bad_csum();
        test_wrap();
        test_hdr_errors();
        test_index_and_truncate();
        test_reset_mid();
        total++; if (overlap !== 0) begin bad++; $display("FAIL wr_complete_overlap got=%0d exp=0", overlap); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
